// File: rtl/mmio_kbd_io_pkg.sv
// Shared definitions for the keyboard/LED MMIO peripheral: register offsets,
// CTRL/STATUS bit positions and the packed scancode FIFO entry.
package mmio_kbd_pkg;

  // Word offsets inside the 32-byte register window
  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_SHIFT  = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_DATA   = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_IE     = 3'd5;

  // CTRL write bits
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // STATUS read fields
  localparam int ST_NOT_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT      = 1;
  localparam int ST_OVF_BIT       = 2;
  localparam int ST_COUNT_LSB     = 8;
  localparam int ST_COUNT_W       = 9;

  // The code field is sized for the widest supported scancode; narrower
  // codes are zero-extended so the DATA word layout never changes.
  localparam int KEY_W_MAX = 16;

  typedef struct packed {
    logic [2:0]           shift;
    logic [KEY_W_MAX-1:0] code;
  } kbd_entry_t;

  // DATA register layout: shift in [18:16], code in [15:0]
  function automatic logic [31:0] entry_to_word(input kbd_entry_t e);
    return {13'b0, e.shift, e.code};
  endfunction

endpackage

// File: rtl/mmio_kbd_io_if.sv
// CPU data-bus interface seen by the keyboard/LED peripheral.
// master = CPU side, slave = peripheral side.
interface mmio_kbd_io_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] dataAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output MemRead,
    output dataAddr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  MemRead,
    input  dataAddr,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/mmio_kbd_io_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, synchronous flush
// and occupancy count. Push while full is accepted only when a pop frees a
// slot in the same cycle; pop while empty is ignored; flush overrides both.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next pointer/count state; a pop in the same cycle makes room for a push
  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & ~flush & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers and count, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_kbd_io.sv
// Memory-mapped keyboard/LED peripheral: LED register, live shift status,
// buffered scancode FIFO with read-to-pop and sticky overflow flag.
// Optional feature macro: MMIO_KBD_IRQ_EN adds the IE register (offset 5)
// and the registered irq output.
module mmio_kbd_io
  import mmio_kbd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          LED_W      = 12,
  parameter int          KEY_W      = 8,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic             clk_pix,
  input  logic             rst,
  mmio_kbd_io_if.slave     bus,
  input  logic [KEY_W-1:0] keyCode,
  input  logic             dataReady,
  input  logic [2:0]       shift,
  output logic [LED_W-1:0] led
`ifdef MMIO_KBD_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             hit;
  logic [2:0]       off;
  logic             led_we, ctrl_we;
  logic             flush, clr_ovf;
  logic             push_req, pop_req, ovf_event;
  logic [LED_W-1:0] led_q, led_d;
  logic             dr_q, dr_d;
  logic             armed_q, armed_d;
  logic             ovf_q, ovf_d;
  kbd_entry_t       new_entry;
  kbd_entry_t       head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{bus.dataAddr[1:0], bus.WriteData};

  // Address decode and bus-side strobes
  always_comb begin
    hit     = (bus.dataAddr[31:5] == BASE_ADDR[31:5]);
    off     = bus.dataAddr[4:2];
    led_we  = bus.MemWrite & hit & (off == OFF_LED);
    ctrl_we = bus.MemWrite & hit & (off == OFF_CTRL);
    flush   = ctrl_we & bus.WriteData[CTRL_FLUSH_BIT];
    clr_ovf = ctrl_we & bus.WriteData[CTRL_CLR_OVF_BIT];
    pop_req = bus.MemRead & hit & (off == OFF_DATA) & ~fifo_empty;
  end

  // Keyboard edge detect; armed_q blocks a push until dataReady has been
  // seen low once after reset, so a level held through reset is not a key
  always_comb begin
    dr_d            = dataReady;
    armed_d         = armed_q | ~dataReady;
    push_req        = dataReady & ~dr_q & armed_q;
    new_entry.shift = shift;
    new_entry.code  = KEY_W_MAX'(keyCode);
    ovf_event       = push_req & fifo_full & ~pop_req & ~flush;
  end

  // LED register and sticky overflow; overflow set beats clear
  always_comb begin
    led_d = led_q;
    if (led_we) led_d = bus.WriteData[LED_W-1:0];
    ovf_d = ovf_q;
    if (clr_ovf)   ovf_d = 1'b0;
    if (ovf_event) ovf_d = 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      led_q   <= '0;
      dr_q    <= 1'b0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      dr_q    <= dr_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
    end
  end

  assign led = led_q;

  sync_fifo #(
    .WIDTH ($bits(kbd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_pix),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .flush (flush),
    .wdata (new_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef MMIO_KBD_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;

  // Interrupt enable register and registered interrupt request
  always_comb begin
    ie_d = ie_q;
    if (bus.MemWrite & hit & (off == OFF_IE)) ie_d = bus.WriteData[0];
    irq_d = (~fifo_empty | ovf_q) & ie_q;
  end

  // Interrupt state registers
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  // Combinational read mux; DATA shows the pre-pop head in the pop cycle
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_LED:    rdata = 32'(led_q);
        OFF_SHIFT:  rdata = 32'(shift);
        OFF_STATUS: begin
          rdata[ST_NOT_EMPTY_BIT]               = ~fifo_empty;
          rdata[ST_FULL_BIT]                    = fifo_full;
          rdata[ST_OVF_BIT]                     = ovf_q;
          rdata[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(fifo_count);
        end
        OFF_DATA: begin
          if (!fifo_empty) rdata = entry_to_word(head);
        end
`ifdef MMIO_KBD_IRQ_EN
        OFF_IE:     rdata = 32'(ie_q);
`endif
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;

endmodule
